// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB slice first,
// with the inter-slice carry held in a register and a start/busy/done handshake.
module chunked_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW    = CHUNK + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, res_q, res_c;
    logic             carry_q, sub_q;
    logic [IDX_W-1:0] idx_q;
    logic [CHUNK-1:0] a_s, b_s;
    logic [PW-1:0]    part;
    logic             c_msb, last;
    int unsigned      base;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One slice of the ripple; carry into the slice MSB recovered from its sum bit
    always_comb begin
        base  = 32'(idx_q) * CHUNK;
        a_s   = a_q[base +: CHUNK];
        b_s   = b_q[base +: CHUNK];
        part  = PW'(a_s) + PW'(b_s) + PW'(carry_q);
        c_msb = part[CHUNK-1] ^ a_s[CHUNK-1] ^ b_s[CHUNK-1];
        res_c = res_q;
        res_c[base +: CHUNK] = part[CHUNK-1:0];
        last  = (idx_q == LAST_IDX);
    end

    // Operand capture, slice accumulation and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            idx_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= (state_d == RUN);
            if (state_q == IDLE) begin
                if (start) begin
                    a_q     <= a;
                    b_q     <= sub ? ~b : b;
                    carry_q <= ci ^ sub;
                    sub_q   <= sub;
                    idx_q   <= '0;
                end
            end else begin
                res_q   <= res_c;
                carry_q <= part[CHUNK];
                idx_q   <= idx_q + IDX_W'(1);
                if (last) begin
                    sum  <= res_c;
                    co   <= part[CHUNK] ^ sub_q;
                    ovf  <= c_msb ^ part[CHUNK];
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
